fetch_pc_unit: RTL and testbench

- PC/fetch front stage, directly upstream of the IF/ID latch and a consumer of the pipeline controller's stall, flush and flush_pc outputs.
- Holds the architectural fetch PC and issues one instruction-bus request at a time.
- Asserts stallreq_if while a fetch is outstanding, which drives bit 0 of the controller's stallreq.
- Applies branch and exception redirects, and discards in-flight fetches killed by a flush.

---
 rtl/fetch_pc_unit_pkg.sv | 30 +++
 rtl/fetch_pc_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// fetch_pc_unit_pkg : shared widths, stage indices, reset vector, fetch states
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pc_unit_pkg;

  localparam int STAGES_W   = 5;
  localparam int STAGE_PC   = 0;
  localparam int ADDR_BUS_W = 32;
  localparam int DATA_BUS_W = 32;

  localparam logic [ADDR_BUS_W-1:0] BASE_BTS  = 32'hBFC0_0000;
  localparam logic [4:0]            EXCT_ADEL = 5'h04;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_KILL  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : PC register, single-outstanding instruction fetch, redirects
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(BASE_BTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES_W-1:0]   stall,
  input  logic [STAGES_W-1:0]   flush,
  input  logic [ADDR_W-1:0]     flush_pc,
  input  logic                  br_flag,
  input  logic [ADDR_W-1:0]     br_addr,
  output logic                  ibus_en,
  output logic [ADDR_W-1:0]     ibus_addr,
  input  logic                  ibus_valid,
  input  logic [DATA_BUS_W-1:0] ibus_rdata,
  output logic                  stallreq_if,
  output logic                  if_valid,
  output logic [ADDR_W-1:0]     if_pc,
  output logic [DATA_BUS_W-1:0] if_inst,
  output logic                  if_exc
);

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_pc, w_pc_nxt, w_pc_adv;
  logic                  r_pend, w_pend_nxt;
  logic [ADDR_W-1:0]     r_pend_addr, w_pend_addr_nxt;
  logic [DATA_BUS_W-1:0] r_buf, w_buf_nxt;
  logic                  r_if_valid, r_if_exc;
  logic [ADDR_W-1:0]     r_if_pc;
  logic [DATA_BUS_W-1:0] r_if_inst;

  logic                  w_flush, w_stall, w_pc_misal, w_adv_misal;
  logic                  w_issue_req, w_wait_req, w_advance;
  logic                  w_dlv, w_dlv_exc;
  logic [DATA_BUS_W-1:0] w_dlv_inst;
  logic                  w_unused;

  assign w_unused    = ^{stall[STAGES_W-1:1], flush[STAGES_W-1:1]};
  assign w_flush     = flush[STAGE_PC];
  assign w_pc_misal  = misaligned(r_pc[1:0]);
  assign w_pc_adv    = r_pend ? r_pend_addr : r_pc + ADDR_W'(4);
  assign w_adv_misal = misaligned(w_pc_adv[1:0]);

  // stallreq_if must not depend on stall, so the WAIT-state reissue is kept out of it
  assign w_issue_req = !rst && (r_state == ST_ISSUE) && !w_pc_misal;
  assign stallreq_if = !rst && (((r_state == ST_WAIT) && !ibus_valid) || w_issue_req);
  assign w_stall     = stall[STAGE_PC] && !stallreq_if;

  assign ibus_en     = !rst && (w_issue_req || w_wait_req);
  assign ibus_addr   = (r_state == ST_ISSUE) ? r_pc : w_pc_adv;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_advance   = 1'b0;
    w_wait_req  = 1'b0;
    w_dlv       = 1'b0;
    w_dlv_inst  = r_buf;
    w_dlv_exc   = 1'b0;

    case (r_state)
      ST_ISSUE: begin
        if (w_flush) begin
          w_pc_nxt    = flush_pc;
          w_state_nxt = w_pc_misal ? ST_ISSUE : ST_KILL;
        end else if (w_pc_misal) begin
          w_dlv      = 1'b1;
          w_dlv_exc  = 1'b1;
          w_dlv_inst = '0;
          w_advance  = !w_stall;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ibus_valid) begin
          if (w_flush) begin
            w_pc_nxt    = flush_pc;
            w_state_nxt = ST_ISSUE;
          end else if (!w_stall) begin
            w_dlv       = 1'b1;
            w_dlv_inst  = ibus_rdata;
            w_advance   = 1'b1;
            w_wait_req  = !w_adv_misal;
            w_state_nxt = w_adv_misal ? ST_ISSUE : ST_WAIT;
          end else begin
            w_buf_nxt   = ibus_rdata;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_flush) begin
          w_pc_nxt    = flush_pc;
          w_state_nxt = ST_KILL;
        end
      end
      ST_KILL: begin
        if (w_flush) w_pc_nxt = flush_pc;
        if (ibus_valid) w_state_nxt = ST_ISSUE;
      end
      ST_HOLD: begin
        if (w_flush) begin
          w_pc_nxt    = flush_pc;
          w_state_nxt = ST_ISSUE;
        end else if (!w_stall) begin
          w_dlv       = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_ISSUE;
    endcase

    if (w_advance) w_pc_nxt = w_pc_adv;

    // A redirect overrides any branch seen in the same cycle
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    if (w_flush) begin
      w_pend_nxt = 1'b0;
    end else if (br_flag) begin
      w_pend_nxt      = 1'b1;
      w_pend_addr_nxt = br_addr;
    end else if (w_advance) begin
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ISSUE;
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_buf       <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
      r_if_exc    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_buf       <= w_buf_nxt;
      r_if_valid  <= w_dlv;
      if (w_dlv) begin
        r_if_pc   <= r_pc;
        r_if_inst <= w_dlv_inst;
        r_if_exc  <= w_dlv_exc;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_exc   = r_if_exc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : bus-model driven scoreboard bench for fetch_pc_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } dlv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  stall = '0;
  logic [4:0]  flush = '0;
  logic [31:0] flush_pc = '0;
  logic        br_flag = 1'b0;
  logic [31:0] br_addr = '0;
  logic        ibus_en;
  logic [31:0] ibus_addr;
  logic        ibus_valid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        stallreq_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_exc;

  fetch_pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .br_flag    (br_flag),
    .br_addr    (br_addr),
    .ibus_en    (ibus_en),
    .ibus_addr  (ibus_addr),
    .ibus_valid (ibus_valid),
    .ibus_rdata (ibus_rdata),
    .stallreq_if(stallreq_if),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_exc     (if_exc)
  );

  always #5 clk = ~clk;

  // next-cycle drive values, applied at the falling edge
  logic        d_rst = 1'b1;
  logic [4:0]  d_stall = '0;
  logic [4:0]  d_flush = '0;
  logic [31:0] d_flush_pc = '0;
  logic        d_br = 1'b0;
  logic [31:0] d_br_addr = '0;

  // memory model and scoreboard
  int          lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic        mem_kill = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] aq[$];
  dlv_t        dq[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_dlv = 0;
  int   n_sreq = 0;
  logic rst_prev = 1'b0;
  logic saw_en = 1'b0;
  logic s_if_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic        ret;
    logic        outst;
    logic        kill_pre;
    logic [31:0] ret_addr;
    dlv_t        e;
    @(negedge clk);
    rst      = d_rst;
    stall    = d_stall;
    flush    = d_flush;
    flush_pc = d_flush_pc;
    br_flag  = d_br;
    br_addr  = d_br_addr;
    ret      = 1'b0;
    outst    = mem_busy;
    kill_pre = mem_kill;
    ret_addr = mem_addr;
    ibus_valid = 1'b0;
    ibus_rdata = '0;
    if (rst) begin
      mem_busy = 1'b0;
      mem_kill = 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        ret        = 1'b1;
        ibus_valid = 1'b1;
        ibus_rdata = mem_word(mem_addr);
        mem_busy   = 1'b0;
        mem_kill   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
    s_if_valid = if_valid;
    saw_en     = ibus_en;
    if (rst) begin
      check("rst_ibus_en", 32'(ibus_en), 32'd0);
      check("rst_stallreq", 32'(stallreq_if), 32'd0);
      if (rst_prev) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_if_exc", 32'(if_exc), 32'd0);
      end
      dq.delete();
    end else begin
      if (stallreq_if) n_sreq++;
      check("stallreq", 32'(stallreq_if),
            32'((outst && !kill_pre && !ibus_valid) || (ibus_en && !ibus_valid)));
      if (if_valid) begin
        n_dlv++;
        if (dq.size() == 0) begin
          check("spurious_dlv", 32'(if_valid), 32'd0);
        end else begin
          e = dq.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_inst", if_inst, e.inst);
          check("if_exc", 32'(if_exc), 32'(e.exc));
        end
      end
      if (ibus_en) begin
        check("one_outstanding", 32'(mem_busy), 32'd0);
        if (aq.size() != 0) check("ibus_addr", ibus_addr, aq.pop_front());
        mem_busy = 1'b1;
        mem_cnt  = lat - 1;
        mem_addr = ibus_addr;
        mem_kill = flush[0];
      end else if (flush[0] && mem_busy) begin
        mem_kill = 1'b1;
      end
      if (ret && !kill_pre && !flush[0])
        dq.push_back('{pc: ret_addr, inst: mem_word(ret_addr), exc: 1'b0});
    end
    rst_prev = rst;
    @(posedge clk);
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!saw_en && n < max);
    check("req_timeout", 32'(saw_en), 32'd1);
  endtask

  initial begin
    // zero-wait memory, back-to-back fetch
    lat = 1;
    repeat (3) cycle();
    d_rst = 1'b0;
    for (int i = 0; i < 6; i++) aq.push_back(32'hBFC0_0000 + 32'(4 * i));
    n_dlv = 0;
    n_sreq = 0;
    repeat (8) cycle();
    check("t1_dlv_count", 32'(n_dlv), 32'd6);
    check("t1_sreq_count", 32'(n_sreq), 32'd1);
    check("t1_aq_left", 32'(aq.size()), 32'd0);

    // three-cycle memory latency
    lat = 3;
    d_rst = 1'b1;
    repeat (2) cycle();
    d_rst = 1'b0;
    aq.delete();
    for (int i = 0; i < 4; i++) aq.push_back(32'hBFC0_0000 + 32'(4 * i));
    n_dlv = 0;
    n_sreq = 0;
    repeat (14) cycle();
    check("t2_dlv_count", 32'(n_dlv), 32'd4);
    check("t2_sreq_count", 32'(n_sreq), 32'd10);
    check("t2_aq_left", 32'(aq.size()), 32'd0);

    // flush while waiting: returned word is dropped
    wait_req(8);
    d_flush = 5'b00001;
    d_flush_pc = 32'h8000_0180;
    cycle();
    d_flush = '0;
    aq.push_back(32'h8000_0180);
    wait_req(8);
    check("t3_aq_left", 32'(aq.size()), 32'd0);

    // branch during a slow fetch redirects the following request
    d_br = 1'b1;
    d_br_addr = 32'hBFC0_0100;
    cycle();
    d_br = 1'b0;
    aq.push_back(32'hBFC0_0100);
    wait_req(8);
    check("t4_aq_left", 32'(aq.size()), 32'd0);

    // misaligned redirect target raises AdEL without a bus request
    for (int i = 0; i < 3; i++)
      dq.push_back('{pc: 32'h8000_0182 + 32'(4 * i), inst: 32'd0, exc: 1'b1});
    d_flush = 5'b00001;
    d_flush_pc = 32'h8000_0182;
    cycle();
    d_flush = '0;
    repeat (5) cycle();
    lat = 1;
    aq.push_back(32'h8000_0200);
    d_flush = 5'b00001;
    d_flush_pc = 32'h8000_0200;
    cycle();
    d_flush = '0;
    wait_req(4);
    check("t5_dq_left", 32'(dq.size()), 32'd0);
    check("t5_aq_left", 32'(aq.size()), 32'd0);

    // downstream stall on return, then reset while holding
    d_stall = 5'b00001;
    cycle();
    cycle();
    check("t6_hold_q1", 32'(s_if_valid), 32'd0);
    d_stall = '0;
    cycle();
    check("t6_hold_q2", 32'(s_if_valid), 32'd0);
    cycle();
    check("t6_hold_dlv", 32'(s_if_valid), 32'd1);
    d_stall = 5'b00001;
    cycle();
    d_rst = 1'b1;
    cycle();
    cycle();
    d_rst = 1'b0;
    d_stall = '0;
    aq.delete();
    aq.push_back(32'hBFC0_0000);
    wait_req(4);
    check("t6_aq_left", 32'(aq.size()), 32'd0);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
